// File: rtl/rbm_vote_argmax_pkg.sv
// Shared definitions for the RBM vote/argmax stage.
//   state_e     : scan FSM states
//   clog2_min1  : ceil(log2(n)), at least 1, used to size the class index
package rbm_vote_argmax_pkg;

    localparam int unsigned DefBitlength = 12;
    localparam int unsigned DefOutputDim = 2;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rbm_vote_argmax_if.sv
// Result/handshake bundle between the RBM top, the argmax stage and its consumer.
//   finish      : level done flag from the RBM top
//   ScoreData   : packed signed scores, element g at [g*bitlength +: bitlength]
//   out_ready   : consumer accepts the result
//   out_valid   : result fields valid and stable
//   class_idx   : winning class index
//   class_score : winning score
//   margin      : winner minus runner-up, saturated
//   saturated   : a captured score hit +/-Inf
//   dropped     : sticky, a finish edge arrived while busy
// Modport slave is the argmax stage's view, master the producer/consumer view.
interface rbm_vote_argmax_if
    import rbm_vote_argmax_pkg::*;
#(
    parameter int unsigned bitlength  = DefBitlength,
    parameter int unsigned output_dim = DefOutputDim
);
    localparam int unsigned IDX_W = clog2_min1(output_dim);

    logic                           finish;
    logic [output_dim*bitlength-1:0] ScoreData;
    logic                           out_ready;
    logic                           out_valid;
    logic [IDX_W-1:0]               class_idx;
    logic [bitlength-1:0]           class_score;
    logic [bitlength-1:0]           margin;
    logic                           saturated;
    logic                           dropped;

    modport slave (
        input  finish, ScoreData, out_ready,
        output out_valid, class_idx, class_score, margin, saturated, dropped
    );

    modport master (
        output finish, ScoreData, out_ready,
        input  out_valid, class_idx, class_score, margin, saturated, dropped
    );

endinterface

// File: rtl/rbm_sat_sub.sv
// Saturating signed subtractor: diff = clamp(a - b, -Inf, Inf).
//   a, b : signed operands, bitlength wide
//   diff : signed result, bitlength wide
// The difference is formed one bit wider so it cannot wrap before clamping.
module rbm_sat_sub #(
    parameter int unsigned         bitlength = 12,
    parameter logic [bitlength-1:0] Inf      = {1'b0, {(bitlength-1){1'b1}}}
) (
    input  logic signed [bitlength-1:0] a,
    input  logic signed [bitlength-1:0] b,
    output logic signed [bitlength-1:0] diff
);

    localparam logic signed [bitlength:0] InfW    = {1'b0, Inf};
    localparam logic signed [bitlength:0] NegInfW = -InfW;

    logic signed [bitlength:0] wide;

    always_comb begin
        wide = $signed({a[bitlength-1], a}) - $signed({b[bitlength-1], b});
        if (wide > InfW) begin
            diff = InfW[bitlength-1:0];
        end else if (wide < NegInfW) begin
            diff = NegInfW[bitlength-1:0];
        end else begin
            diff = wide[bitlength-1:0];
        end
    end

endmodule

// File: rtl/rbm_vote_argmax.sv
// Argmax over the RBM class score vector.
// On a 0->1 edge of finish while idle, the score vector is captured, then scanned one element
// per clock to find the best score (ties keep the lowest index) and the runner-up. The result
// is held with out_valid until accepted via out_ready.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : rbm_vote_argmax_if.slave (finish/ScoreData in, result + valid/ready)
module rbm_vote_argmax
    import rbm_vote_argmax_pkg::*;
#(
    parameter int unsigned          bitlength  = DefBitlength,
    parameter int unsigned          output_dim = DefOutputDim,
    parameter logic [bitlength-1:0] Inf        = {1'b0, {(bitlength-1){1'b1}}}
) (
    input logic              clock,
    input logic              reset,
    rbm_vote_argmax_if.slave bus
);

    localparam int unsigned IDX_W = clog2_min1(output_dim);

    typedef logic signed [bitlength-1:0] score_t;

    // Most-negative code: best/second start here so any real score displaces them.
    localparam score_t NegMax  = {1'b1, {(bitlength-1){1'b0}}};
    localparam score_t InfS    = Inf;
    localparam score_t NegInfS = ~Inf + 1'b1;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(output_dim - 1);

    state_e           state_q, state_d;
    logic             finish_d;
    logic             rise;
    logic             capture;
    score_t           score_q [output_dim];
    logic [IDX_W-1:0] idx_q, idx_d;
    score_t           best_q, best_d, second_q, second_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             sat_acc_q, sat_acc_d;

    // One-element scan step, evaluated on the current index.
    score_t           s;
    score_t           scan_best, scan_second;
    logic [IDX_W-1:0] scan_idx;
    logic             scan_sat;
    score_t           margin_w;

    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] class_idx_q, class_idx_d;
    score_t           class_score_q, class_score_d;
    score_t           margin_q, margin_d;
    logic             saturated_q, saturated_d;
    logic             dropped_q, dropped_d;

    assign rise = bus.finish & ~finish_d;

    always_comb begin
        s           = score_q[idx_q];
        scan_best   = best_q;
        scan_second = second_q;
        scan_idx    = best_idx_q;
        if (s > best_q) begin
            scan_second = best_q;
            scan_best   = s;
            scan_idx    = idx_q;
        end else if (s > second_q) begin
            scan_second = s;
        end
        scan_sat = sat_acc_q | (s == InfS) | (s == NegInfS);
    end

    rbm_sat_sub #(
        .bitlength(bitlength),
        .Inf      (Inf)
    ) u_margin_sub (
        .a   (scan_best),
        .b   (scan_second),
        .diff(margin_w)
    );

    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        idx_d         = idx_q;
        best_d        = best_q;
        second_d      = second_q;
        best_idx_d    = best_idx_q;
        sat_acc_d     = sat_acc_q;
        out_valid_d   = out_valid_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        margin_d      = margin_q;
        saturated_d   = saturated_q;
        dropped_d     = dropped_q;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    capture    = 1'b1;
                    idx_d      = '0;
                    best_d     = NegMax;
                    second_d   = NegMax;
                    best_idx_d = '0;
                    sat_acc_d  = 1'b0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (rise) dropped_d = 1'b1;
                best_d     = scan_best;
                second_d   = scan_second;
                best_idx_d = scan_idx;
                sat_acc_d  = scan_sat;
                if (idx_q == LastIdx) begin
                    state_d       = StDone;
                    out_valid_d   = 1'b1;
                    class_idx_d   = scan_idx;
                    class_score_d = scan_best;
                    margin_d      = margin_w;
                    saturated_d   = scan_sat;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                // A rise on the accepting edge is also counted as dropped.
                if (rise) dropped_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            finish_d      <= 1'b0;
            idx_q         <= '0;
            best_q        <= '0;
            second_q      <= '0;
            best_idx_q    <= '0;
            sat_acc_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            margin_q      <= '0;
            saturated_q   <= 1'b0;
            dropped_q     <= 1'b0;
            for (int g = 0; g < int'(output_dim); g++) begin
                score_q[g] <= '0;
            end
        end else begin
            state_q       <= state_d;
            finish_d      <= bus.finish;
            idx_q         <= idx_d;
            best_q        <= best_d;
            second_q      <= second_d;
            best_idx_q    <= best_idx_d;
            sat_acc_q     <= sat_acc_d;
            out_valid_q   <= out_valid_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            margin_q      <= margin_d;
            saturated_q   <= saturated_d;
            dropped_q     <= dropped_d;
            if (capture) begin
                for (int g = 0; g < int'(output_dim); g++) begin
                    score_q[g] <= $signed(bus.ScoreData[g*bitlength +: bitlength]);
                end
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.class_idx   = class_idx_q;
    assign bus.class_score = class_score_q;
    assign bus.margin      = margin_q;
    assign bus.saturated   = saturated_q;
    assign bus.dropped     = dropped_q;

endmodule

// File: tb/tb_rbm_vote_argmax.sv
// Directed bench for rbm_vote_argmax: a 2-class and a 4-class instance share clock and reset.
module tb_rbm_vote_argmax;

    logic clock;
    logic reset;

    int n_pass  = 0;
    int n_check = 0;

    rbm_vote_argmax_if #(.bitlength(12), .output_dim(2)) bus2 ();
    rbm_vote_argmax_if #(.bitlength(12), .output_dim(4)) bus4 ();

    rbm_vote_argmax #(.bitlength(12), .output_dim(2)) dut2 (
        .clock(clock),
        .reset(reset),
        .bus  (bus2)
    );

    rbm_vote_argmax #(.bitlength(12), .output_dim(4)) dut4 (
        .clock(clock),
        .reset(reset),
        .bus  (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    int valid_seen;

    initial begin
        reset          = 1'b0;
        bus2.finish    = 1'b0;
        bus2.ScoreData = '0;
        bus2.out_ready = 1'b0;
        bus4.finish    = 1'b0;
        bus4.ScoreData = '0;
        bus4.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", 64'(bus2.out_valid), 64'd0);
        chk("rst_idx", 64'(bus2.class_idx), 64'd0);
        chk("rst_score", 64'(bus2.class_score), 64'd0);
        chk("rst_margin", 64'(bus2.margin), 64'd0);
        chk("rst_sat", 64'(bus2.saturated), 64'd0);
        chk("rst_dropped", 64'(bus2.dropped), 64'd0);
        reset = 1'b1;
        tick();

        // T1: {5,-3}
        bus2.ScoreData = {12'hFFD, 12'd5};
        bus2.finish    = 1'b1;
        tick();
        chk("t1_valid_e0", 64'(bus2.out_valid), 64'd0);
        tick();
        chk("t1_valid_e1", 64'(bus2.out_valid), 64'd0);
        tick();
        chk("t1_valid_e2", 64'(bus2.out_valid), 64'd1);
        chk("t1_idx", 64'(bus2.class_idx), 64'd0);
        chk("t1_score", 64'(bus2.class_score), 64'd5);
        chk("t1_margin", 64'(bus2.margin), 64'd8);
        chk("t1_sat", 64'(bus2.saturated), 64'd0);
        chk("t1_dropped", 64'(bus2.dropped), 64'd0);
        bus2.finish    = 1'b0;
        bus2.out_ready = 1'b1;
        tick();
        chk("t1_accept_valid", 64'(bus2.out_valid), 64'd0);
        chk("t1_hold_score", 64'(bus2.class_score), 64'd5);
        bus2.out_ready = 1'b0;

        // T2: 4 classes {-7,20,20,4}, tie keeps lowest index
        bus4.ScoreData = {12'd4, 12'd20, 12'd20, 12'hFF9};
        bus4.finish    = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("t2_valid_e3", 64'(bus4.out_valid), 64'd0);
        tick();
        chk("t2_valid_e4", 64'(bus4.out_valid), 64'd1);
        chk("t2_idx", 64'(bus4.class_idx), 64'd1);
        chk("t2_score", 64'(bus4.class_score), 64'd20);
        chk("t2_margin", 64'(bus4.margin), 64'd0);
        chk("t2_sat", 64'(bus4.saturated), 64'd0);
        bus4.out_ready = 1'b1;
        bus4.finish    = 1'b0;
        tick();
        chk("t2_accept_valid", 64'(bus4.out_valid), 64'd0);
        bus4.out_ready = 1'b0;

        // T3: {Inf,-Inf}
        bus2.ScoreData = {12'h801, 12'h7FF};
        bus2.finish    = 1'b1;
        tick();
        tick();
        tick();
        chk("t3_valid", 64'(bus2.out_valid), 64'd1);
        chk("t3_idx", 64'(bus2.class_idx), 64'd0);
        chk("t3_score", 64'(bus2.class_score), 64'h7FF);
        chk("t3_margin", 64'(bus2.margin), 64'h7FF);
        chk("t3_sat", 64'(bus2.saturated), 64'd1);

        // T4: hold without ready, then a finish pulse in DONE
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_stable", 64'({bus2.out_valid, bus2.class_idx, bus2.class_score,
                                  bus2.margin, bus2.saturated}),
                64'({1'b1, 1'b0, 12'h7FF, 12'h7FF, 1'b1}));
        end
        bus2.ScoreData = {12'd2, 12'd1};
        bus2.finish    = 1'b0;
        tick();
        bus2.finish = 1'b1;
        tick();
        chk("t4_dropped", 64'(bus2.dropped), 64'd1);
        chk("t4_no_recap", 64'(bus2.class_score), 64'h7FF);
        chk("t4_still_valid", 64'(bus2.out_valid), 64'd1);
        bus2.finish    = 1'b0;
        bus2.out_ready = 1'b1;
        tick();
        chk("t4_accept_valid", 64'(bus2.out_valid), 64'd0);
        bus2.out_ready = 1'b0;
        tick();
        chk("t4_dropped_sticky", 64'(bus2.dropped), 64'd1);
        chk("t4_idle_valid", 64'(bus2.out_valid), 64'd0);

        // T5: finish held high for 20 cycles yields one result
        bus2.ScoreData = {12'd9, 12'd3};
        bus2.finish    = 1'b1;
        bus2.out_ready = 1'b1;
        valid_seen     = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus2.out_valid) valid_seen++;
        end
        chk("t5_one_result", 64'(valid_seen), 64'd1);
        chk("t5_idx", 64'(bus2.class_idx), 64'd1);
        chk("t5_score", 64'(bus2.class_score), 64'd9);
        chk("t5_margin", 64'(bus2.margin), 64'd6);
        bus2.finish = 1'b0;
        tick();
        bus2.ScoreData = {12'd2, 12'd1};
        bus2.finish    = 1'b1;
        tick();
        tick();
        tick();
        chk("t5b_valid", 64'(bus2.out_valid), 64'd1);
        chk("t5b_idx", 64'(bus2.class_idx), 64'd1);
        chk("t5b_score", 64'(bus2.class_score), 64'd2);
        chk("t5b_margin", 64'(bus2.margin), 64'd1);
        tick();
        chk("t5b_accept_valid", 64'(bus2.out_valid), 64'd0);

        // T6: asynchronous reset during SCAN
        bus2.out_ready = 1'b0;
        bus2.finish    = 1'b0;
        tick();
        bus2.ScoreData = {12'hFFD, 12'd5};
        bus2.finish    = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", 64'(bus2.out_valid), 64'd0);
        chk("t6_idx", 64'(bus2.class_idx), 64'd0);
        chk("t6_score", 64'(bus2.class_score), 64'd0);
        chk("t6_margin", 64'(bus2.margin), 64'd0);
        chk("t6_sat", 64'(bus2.saturated), 64'd0);
        chk("t6_dropped", 64'(bus2.dropped), 64'd0);
        bus2.finish = 1'b0;
        tick();
        chk("t6_hold_valid", 64'(bus2.out_valid), 64'd0);
        reset = 1'b1;
        tick();
        bus2.ScoreData = {12'd7, 12'hFFE};
        bus2.finish    = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_new_valid", 64'(bus2.out_valid), 64'd1);
        chk("t6_new_idx", 64'(bus2.class_idx), 64'd1);
        chk("t6_new_score", 64'(bus2.class_score), 64'd7);
        chk("t6_new_margin", 64'(bus2.margin), 64'd9);
        chk("t6_new_dropped", 64'(bus2.dropped), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
